// File: rtl/updown_pulse_gen_if.sv
// Button-to-counter step interface.
//   btn_up, btn_down : raw button levels (master -> slave)
//   up, down         : one-cycle step requests (slave -> master)
//   blocked          : conflict lockout indicator (slave -> master)
interface updown_pulse_gen_if;
  logic btn_up;
  logic btn_down;
  logic up;
  logic down;
  logic blocked;

  modport master (output btn_up, output btn_down, input up, input down, input blocked);
  modport slave  (input btn_up, input btn_down, output up, output down, output blocked);
endinterface

// File: rtl/updown_pulse_gen.sv
// Debounced up/down button pulse generator with auto-repeat and conflict lockout.
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : slave side of updown_pulse_gen_if (raw buttons in, step pulses + blocked out)
module updown_pulse_gen #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned REPEAT_DELAY    = 64,
  parameter int unsigned REPEAT_PERIOD   = 16,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  updown_pulse_gen_if.slave bus
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_DLY = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RPT_PER = CNT_W'(REPEAT_PERIOD);

  typedef enum logic [1:0] {IDLE, HOLD_UP, HOLD_DOWN, LOCK} state_t;

  // Channel 0 = up button, channel 1 = down button
  logic [1:0]       raw;
  logic [1:0]       meta;
  logic [1:0]       sync;
  logic [1:0]       deb;
  logic [CNT_W-1:0] db_cnt [2];

  state_t           state;
  logic [CNT_W-1:0] rpt_cnt;
  logic             rpt_on;
  logic             up_q;
  logic             down_q;
  logic             blocked_q;
  logic             rpt_hit;

  assign raw = {bus.btn_down, bus.btn_up};

  // Two-flop synchronizers followed by per-button stable-count debouncers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      sync <= '0;
      deb  <= '0;
      for (int i = 0; i < 2; i++) db_cnt[i] <= '0;
    end else begin
      meta <= raw;
      sync <= meta;
      for (int i = 0; i < 2; i++) begin
        if (sync[i] == deb[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          deb[i]    <= sync[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  // rpt_cnt holds edges elapsed since the last pulse; the first gap uses the delay, later ones the period
  assign rpt_hit = REPEAT_EN && (rpt_cnt == (rpt_on ? RPT_PER : RPT_DLY));

  // Pulse FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rpt_cnt   <= '0;
      rpt_on    <= 1'b0;
      up_q      <= 1'b0;
      down_q    <= 1'b0;
      blocked_q <= 1'b0;
    end else begin
      up_q   <= 1'b0;
      down_q <= 1'b0;
      case (state)
        IDLE: begin
          rpt_cnt <= CNT_W'(1);
          rpt_on  <= 1'b0;
          if (deb[0] && !deb[1]) begin
            state <= HOLD_UP;
            up_q  <= 1'b1;
          end else if (deb[1] && !deb[0]) begin
            state  <= HOLD_DOWN;
            down_q <= 1'b1;
          end else if (deb[0] && deb[1]) begin
            state     <= LOCK;
            blocked_q <= 1'b1;
          end
        end
        HOLD_UP: begin
          if (!deb[0]) begin
            state <= IDLE;
          end else if (deb[1]) begin
            state     <= LOCK;
            blocked_q <= 1'b1;
          end else if (rpt_hit) begin
            up_q    <= 1'b1;
            rpt_cnt <= CNT_W'(1);
            rpt_on  <= 1'b1;
          end else if (REPEAT_EN) begin
            rpt_cnt <= rpt_cnt + CNT_W'(1);
          end
        end
        HOLD_DOWN: begin
          if (!deb[1]) begin
            state <= IDLE;
          end else if (deb[0]) begin
            state     <= LOCK;
            blocked_q <= 1'b1;
          end else if (rpt_hit) begin
            down_q  <= 1'b1;
            rpt_cnt <= CNT_W'(1);
            rpt_on  <= 1'b1;
          end else if (REPEAT_EN) begin
            rpt_cnt <= rpt_cnt + CNT_W'(1);
          end
        end
        LOCK: begin
          if (!deb[0] && !deb[1]) begin
            state     <= IDLE;
            blocked_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.up      = up_q;
  assign bus.down    = down_q;
  assign bus.blocked = blocked_q;

endmodule

// File: tb/tb_updown_pulse_gen.sv
// Self-checking bench: two DUTs (auto-repeat on / off) share stimulus; checked per cycle
// against a window-based reference model, plus segment tables and fixed-edge sequences.
module tb_updown_pulse_gen;

  localparam int unsigned D   = 4;
  localparam int unsigned DLY = 10;
  localparam int unsigned PER = 5;

  logic clk = 1'b0;
  logic rst;
  logic btn_up;
  logic btn_dn;

  always #5 clk = ~clk;

  updown_pulse_gen_if ifa ();
  updown_pulse_gen_if ifb ();

  assign ifa.btn_up   = btn_up;
  assign ifa.btn_down = btn_dn;
  assign ifb.btn_up   = btn_up;
  assign ifb.btn_down = btn_dn;

  updown_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .REPEAT_EN(1'b1))
    dut_a (.clk(clk), .rst(rst), .bus(ifa));
  updown_pulse_gen #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER), .REPEAT_EN(1'b0))
    dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: raw-sample history windows and behavioural press tracking
  bit q_up[$];
  bit q_dn[$];
  bit m_du, m_dd;
  int m_mode [2];   // 0 idle, 1 up held, 2 down held, 3 lockout
  int m_first[2];   // edge of the first pulse of the current press
  bit m_up[2], m_dn[2], m_blk[2];
  int ec;

  // Observed pulse bookkeeping
  int cnt_ua, cnt_da, cnt_ub, cnt_db;
  int qa_up[$], qa_dn[$], qb_up[$], qb_dn[$];
  int exp_q[$];

  typedef struct {
    bit u; bit d; int n;
    int ua; int da; bit ba;
    int ub; int db; bit bb;
  } seg_t;
  seg_t tbl[8];

  task automatic chk(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %b expected %b", name, ec, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_edges(input string name, input int got[$], input int exp[$]);
    chk_int({name, " count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      chk_int({name, " edge"}, (i < got.size()) ? got[i] : -1, exp[i]);
  endtask

  task automatic model_reset();
    q_up.delete();
    q_dn.delete();
    for (int k = 0; k < D + 2; k++) begin
      q_up.push_back(1'b0);
      q_dn.push_back(1'b0);
    end
    m_du = 1'b0;
    m_dd = 1'b0;
    for (int c = 0; c < 2; c++) begin
      m_mode[c] = 0; m_first[c] = 0;
      m_up[c] = 1'b0; m_dn[c] = 1'b0; m_blk[c] = 1'b0;
    end
    ec = 0;
  endtask

  function automatic bit is_repeat(input int k);
    return (k >= int'(DLY)) && ((k - int'(DLY)) % int'(PER) == 0);
  endfunction

  // One rising edge of the model; decisions use the debounced levels from before the edge
  task automatic model_edge();
    bit rep;
    bit flip;
    ec++;
    for (int c = 0; c < 2; c++) begin
      rep = (c == 0);
      m_up[c] = 1'b0;
      m_dn[c] = 1'b0;
      case (m_mode[c])
        0: begin
          if (m_du && !m_dd) begin m_mode[c] = 1; m_first[c] = ec; m_up[c] = 1'b1; end
          else if (m_dd && !m_du) begin m_mode[c] = 2; m_first[c] = ec; m_dn[c] = 1'b1; end
          else if (m_du && m_dd) m_mode[c] = 3;
        end
        1: begin
          if (!m_du) m_mode[c] = 0;
          else if (m_dd) m_mode[c] = 3;
          else if (rep && is_repeat(ec - m_first[c])) m_up[c] = 1'b1;
        end
        2: begin
          if (!m_dd) m_mode[c] = 0;
          else if (m_du) m_mode[c] = 3;
          else if (rep && is_repeat(ec - m_first[c])) m_dn[c] = 1'b1;
        end
        default: if (!m_du && !m_dd) m_mode[c] = 0;
      endcase
      m_blk[c] = (m_mode[c] == 3);
    end
    // Debounced level flips once the synchronized samples differed from it for D edges running
    q_up.push_front(btn_up); void'(q_up.pop_back());
    q_dn.push_front(btn_dn); void'(q_dn.pop_back());
    flip = 1'b1;
    for (int k = 2; k < D + 2; k++) if (q_up[k] == m_du) flip = 1'b0;
    if (flip) m_du = !m_du;
    flip = 1'b1;
    for (int k = 2; k < D + 2; k++) if (q_dn[k] == m_dd) flip = 1'b0;
    if (flip) m_dd = !m_dd;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    chk("up_a", ifa.up, m_up[0]);
    chk("down_a", ifa.down, m_dn[0]);
    chk("blocked_a", ifa.blocked, m_blk[0]);
    chk("up_b", ifb.up, m_up[1]);
    chk("down_b", ifb.down, m_dn[1]);
    chk("blocked_b", ifb.blocked, m_blk[1]);
    if (ifa.up)   begin cnt_ua++; qa_up.push_back(ec); end
    if (ifa.down) begin cnt_da++; qa_dn.push_back(ec); end
    if (ifb.up)   begin cnt_ub++; qb_up.push_back(ec); end
    if (ifb.down) begin cnt_db++; qb_dn.push_back(ec); end
  endtask

  task automatic clear_obs();
    cnt_ua = 0; cnt_da = 0; cnt_ub = 0; cnt_db = 0;
    qa_up.delete(); qa_dn.delete(); qb_up.delete(); qb_dn.delete();
  endtask

  task automatic run(input int n, input bit u, input bit d);
    btn_up = u;
    btn_dn = d;
    repeat (n) tick();
  endtask

  // Called at a falling edge; outputs must clear asynchronously
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_up_a", ifa.up, 1'b0);
    chk("rst_down_a", ifa.down, 1'b0);
    chk("rst_blocked_a", ifa.blocked, 1'b0);
    chk("rst_up_b", ifb.up, 1'b0);
    chk("rst_down_b", ifb.down, 1'b0);
    chk("rst_blocked_b", ifb.blocked, 1'b0);
    model_reset();
    repeat (3) tick();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    btn_up = 1'b0;
    btn_dn = 1'b0;
    model_reset();
    clear_obs();
    repeat (3) tick();
    rst = 1'b0;

    // Segment table: {up, down, cycles, A up/down pulses, A blocked at end, B up/down pulses, B blocked}
    tbl[0] = '{1'b1, 1'b0, 30, 4, 0, 1'b0, 1, 0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 10, 1, 0, 1'b0, 0, 0, 1'b0};
    tbl[2] = '{1'b1, 1'b1, 20, 0, 0, 1'b1, 0, 0, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 10, 0, 0, 1'b1, 0, 0, 1'b1};
    tbl[4] = '{1'b0, 1'b0, 10, 0, 0, 1'b0, 0, 0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 15, 0, 1, 1'b0, 0, 1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 15, 0, 1, 1'b1, 0, 0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 10, 0, 0, 1'b0, 0, 0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      clear_obs();
      run(tbl[i].n, tbl[i].u, tbl[i].d);
      chk_int($sformatf("seg%0d up_a pulses", i), cnt_ua, tbl[i].ua);
      chk_int($sformatf("seg%0d down_a pulses", i), cnt_da, tbl[i].da);
      chk($sformatf("seg%0d blocked_a", i), ifa.blocked, tbl[i].ba);
      chk_int($sformatf("seg%0d up_b pulses", i), cnt_ub, tbl[i].ub);
      chk_int($sformatf("seg%0d down_b pulses", i), cnt_db, tbl[i].db);
      chk($sformatf("seg%0d blocked_b", i), ifb.blocked, tbl[i].bb);
    end

    // Down held 40 cycles: auto-repeat edges
    do_reset();
    clear_obs();
    run(40, 1'b0, 1'b1);
    run(15, 1'b0, 1'b0);
    exp_q = '{7, 17, 22, 27, 32, 37, 42};
    chk_edges("repeat_down_a", qa_dn, exp_q);
    exp_q = '{7};
    chk_edges("single_down_b", qb_dn, exp_q);
    chk_int("repeat_up_a", cnt_ua, 0);

    // Up held 20 cycles without auto-repeat: one pulse on edge 7
    do_reset();
    clear_obs();
    run(20, 1'b1, 1'b0);
    run(10, 1'b0, 1'b0);
    exp_q = '{7};
    chk_edges("single_up_b", qb_up, exp_q);
    chk_int("single_up_b down", cnt_db, 0);

    // Bouncing up button never accepted
    do_reset();
    clear_obs();
    for (int i = 0; i < 15; i++) run(2, (i % 2) == 0, 1'b0);
    run(10, 1'b0, 1'b0);
    chk_int("bounce up_a", cnt_ua, 0);
    chk_int("bounce up_b", cnt_ub, 0);

    // Reset during a repeat pulse with up held, then fresh press after release
    do_reset();
    clear_obs();
    run(17, 1'b1, 1'b0);
    chk("pre-reset pulse up_a", ifa.up, 1'b1);
    do_reset();
    clear_obs();
    run(12, 1'b1, 1'b0);
    exp_q = '{7};
    chk_edges("post-reset up_a", qa_up, exp_q);
    chk_edges("post-reset up_b", qb_up, exp_q);
    run(10, 1'b0, 1'b0);

    // Randomized segments against the model
    for (int s = 0; s < 160; s++) begin
      if ($urandom_range(0, 39) == 0) do_reset();
      run(int'($urandom_range(1, 25)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
